// File: rtl/uart_apb_pkg.sv
// Shared constants and state type for the UART command-frame to APB3 bridge.
package uart_apb_pkg;

  // Command bytes that open a frame
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  // Status bytes returned to the host
  localparam logic [7:0] ST_OK     = 8'h4B;
  localparam logic [7:0] ST_ERR    = 8'h45;
  localparam logic [7:0] ST_BADCMD = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    SETUP,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/uart_apb_master.sv
// Bridge that decodes UART command frames into single APB3 transfers and
// streams a status byte (plus read data for reads) back to the transmitter.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        busy,
  output logic        frame_err
);

  // A zero timeout still needs a one-bit counter so the declarations stay legal.
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;        // write data, then reused as read-data shifter
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           write_q, write_d;
  logic           read_q, read_d;        // only reads have a 4-byte data tail
  logic           stat_sent_q, stat_sent_d;
  logic           rx_ready_q, rx_ready_d;
  logic           tx_valid_q, tx_valid_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           frame_err_q, frame_err_d;

  logic           rx_acc;
  logic           tmo_hit;

  assign rx_acc  = rx_valid && rx_ready_q;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   ((32'(tmo_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign PADDR     = addr_q;
  assign PWDATA    = data_q;
  assign PWRITE    = write_q;
  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

  // Next-state and datapath: frame parsing, APB sequencing, response streaming.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    write_d     = write_q;
    read_d      = read_q;
    stat_sent_d = stat_sent_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_acc) begin
          cnt_d       = 2'd0;
          tmo_d       = '0;
          stat_sent_d = 1'b0;
          write_d     = (rx_data == CMD_WRITE);
          read_d      = (rx_data == CMD_READ);
          if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
            state_d = ADDR;
          end else begin
            // Unknown command: answer with a single marker byte.
            frame_err_d = 1'b1;
            tx_valid_d  = 1'b1;
            tx_data_d   = ST_BADCMD;
            state_d     = RESP;
          end
        end
      end

      ADDR, WDATA: begin
        // An arriving byte takes priority over a timeout in the same cycle.
        if (rx_acc) begin
          tmo_d = '0;
          cnt_d = cnt_q + 2'd1;
          if (state_q == ADDR) addr_d = {addr_q[23:0], rx_data};
          else                 data_d = {data_q[23:0], rx_data};
          if (cnt_q == 2'd3) begin
            if (state_q == ADDR && write_q) state_d = WDATA;
            else                            state_d = SETUP;
          end
        end else if (tmo_hit) begin
          frame_err_d = 1'b1;
          tmo_d       = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      SETUP: state_d = ACCESS;

      ACCESS: begin
        if (PREADY) begin
          if (read_q) data_d = PRDATA;
          tx_data_d   = PSLVERR ? ST_ERR : ST_OK;
          tx_valid_d  = 1'b1;
          stat_sent_d = 1'b0;
          cnt_d       = 2'd0;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (tx_valid_q) begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            if (!read_q || (stat_sent_q && cnt_q == 2'd3)) begin
              stat_sent_d = 1'b0;
              state_d     = IDLE;
            end else if (!stat_sent_q) begin
              stat_sent_d = 1'b1;
              cnt_d       = 2'd0;
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end else begin
          // Gap cycle after an accepted byte: present the next read-data byte.
          tx_valid_d = 1'b1;
          tx_data_d  = data_q[31:24];
          data_d     = {data_q[23:0], 8'h00};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered rx_ready follows the upcoming state, so it stays low during reset.
  always_comb begin
    rx_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      tmo_q       <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      stat_sent_q <= 1'b0;
      rx_ready_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      write_q     <= write_d;
      read_q      <= read_d;
      stat_sent_q <= stat_sent_d;
      rx_ready_q  <= rx_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed self-checking bench for the UART command-frame to APB3 bridge.
module tb_uart_apb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;
  logic        busy;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;

  // Observation counters written only by the monitor.
  int          setup_n = 0;
  int          pen_n = 0;
  int          unstable_n = 0;
  int          ferr_n = 0;
  int          rsp_n = 0;
  logic [7:0]  rsp_buf [0:255];
  logic [31:0] cap_addr = 32'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic        cap_write = 1'b0;

  uart_apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(clk), .PRESETN(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .busy(busy), .frame_err(frame_err)
  );

  initial forever #5 clk = ~clk;

  // Bus and response monitor.
  always @(posedge clk) begin
    if (psel && !penable) begin
      setup_n   <= setup_n + 1;
      cap_addr  <= paddr;
      cap_wdata <= pwdata;
      cap_write <= pwrite;
    end
    if (psel && penable) begin
      pen_n <= pen_n + 1;
      if (paddr !== cap_addr || pwdata !== cap_wdata || pwrite !== cap_write)
        unstable_n <= unstable_n + 1;
    end
    if (tx_valid && tx_ready) begin
      rsp_buf[rsp_n[7:0]] <= tx_data;
      rsp_n <= rsp_n + 1;
    end
    if (frame_err) ferr_n <= ferr_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("rx_accept_timeout", 1'b0, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int total);
    int t = 0;
    while (rsp_n < total && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_count_reached", 64'(rsp_n >= total), 64'd1);
  endtask

  task automatic chk_rsp(input string tag, input int base, input int n, input logic [39:0] exp);
    for (int i = 0; i < n; i++)
      chk(tag, rsp_buf[base + i], exp[8*(n-1-i) +: 8]);
  endtask

  initial begin
    int b0, s0, p0, f0;

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rst", rx_ready, 1'b1);

    // ---- write, PREADY=1 ----
    b0 = rsp_n; s0 = setup_n;
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("wr_setup_psel", {psel, penable}, 2'b10);
    chk("wr_setup_paddr", paddr, 32'h00001004);
    chk("wr_setup_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_setup_pwrite", pwrite, 1'b1);
    chk("wr_setup_rx_ready", rx_ready, 1'b0);
    @(negedge clk);
    chk("wr_access", {psel, penable}, 2'b11);
    @(negedge clk);
    chk("wr_resp_tx", {tx_valid, tx_data}, {1'b1, 8'h4B});
    chk("wr_resp_psel", psel, 1'b0);
    wait_rsp(b0 + 1);
    chk_rsp("wr_rsp", b0, 1, 40'h4B);
    chk("wr_setup_count", setup_n - s0, 1);
    repeat (3) @(negedge clk);
    chk("wr_idle_busy", busy, 1'b0);

    // ---- read with 3 wait states ----
    b0 = rsp_n; p0 = pen_n;
    pready = 1'b0; prdata = 32'h12345678;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    chk("rd_setup_paddr", paddr, 32'h00002000);
    chk("rd_setup_pwrite", pwrite, 1'b0);
    repeat (4) @(negedge clk);
    pready = 1'b1;
    @(negedge clk);
    pready = 1'b0;
    wait_rsp(b0 + 5);
    chk_rsp("rd_rsp", b0, 5, 40'h4B12345678);
    chk("rd_penable_cycles", pen_n - p0, 4);

    // ---- read with PSLVERR ----
    b0 = rsp_n;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h30); send_byte(8'h08);
    wait_rsp(b0 + 5);
    chk_rsp("err_rsp", b0, 5, 40'h45CAFEF00D);
    pslverr = 1'b0;

    // ---- unknown command ----
    b0 = rsp_n; s0 = setup_n; f0 = ferr_n;
    send_byte(8'hA5);
    chk("bad_frame_err", frame_err, 1'b1);
    chk("bad_tx", {tx_valid, tx_data}, {1'b1, 8'h3F});
    wait_rsp(b0 + 1);
    chk_rsp("bad_rsp", b0, 1, 40'h3F);
    repeat (5) @(negedge clk);
    chk("bad_ferr_count", ferr_n - f0, 1);
    chk("bad_no_psel", setup_n - s0, 0);
    chk("bad_rsp_count", rsp_n - b0, 1);

    // ---- timeout after partial frame ----
    b0 = rsp_n; s0 = setup_n; f0 = ferr_n;
    send_byte(8'h57);
    send_byte(8'h00);
    repeat (10) @(negedge clk);
    chk("tmo_not_early", ferr_n - f0, 0);
    chk("tmo_still_busy", busy, 1'b1);
    repeat (20) @(negedge clk);
    chk("tmo_ferr_count", ferr_n - f0, 1);
    chk("tmo_idle", busy, 1'b0);
    chk("tmo_no_psel", setup_n - s0, 0);
    chk("tmo_no_tx", rsp_n - b0, 0);
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_rsp(b0 + 1);
    chk_rsp("tmo_next_rsp", b0, 1, 40'h4B);
    chk("tmo_next_addr", cap_addr, 32'h0000000C);
    chk("tmo_next_wdata", cap_wdata, 32'h01020304);
    chk("tmo_next_write", cap_write, 1'b1);

    // ---- transmitter stall mid-response ----
    b0 = rsp_n;
    prdata = 32'hA1B2C3D4;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    wait_rsp(b0 + 2);
    tx_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_tx", {tx_valid, tx_data}, {1'b1, 8'hB2});
    chk("stall_no_accept", rsp_n - b0, 2);
    tx_ready = 1'b1;
    wait_rsp(b0 + 5);
    chk_rsp("stall_rsp", b0, 5, 40'h4BA1B2C3D4);

    // ---- reset during ACCESS ----
    pready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h04);
    @(negedge clk);
    chk("rst_in_access", {psel, penable}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_psel", {psel, penable}, 2'b00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_paddr", paddr, 32'h0);
    chk("rst_mid_tx_valid", tx_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pready = 1'b1;
    b0 = rsp_n; s0 = setup_n;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_psel", setup_n - s0, 0);
    chk("rst_mid_no_rsp", rsp_n - b0, 0);
    chk("rst_mid_rx_ready", rx_ready, 1'b1);

    chk("addr_data_stable", unstable_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
